// File: rtl/dac_spi_pkg.sv
// Shared frame geometry, counter limits and FSM encoding for the DAC SPI
// frame receiver.
package dac_spi_pkg;

    localparam int FRAME_BITS  = 16;
    localparam int PREFIX_BITS = 4;
    localparam int DATA_BITS   = 12;
    localparam int CNT_W       = 5;

    localparam logic [PREFIX_BITS-1:0] DEFAULT_PREFIX = 4'b0011;
    localparam logic [CNT_W-1:0]       CNT_FULL       = 5'd16;
    localparam logic [CNT_W-1:0]       CNT_SAT        = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } rx_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous input, with registered
// rise/fall pulses and a level output aligned to those pulses.
module sync_edge_det #(
    parameter int   STAGES     = 2,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic clk12MHz,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    always_comb begin
        sync_d[0] = din;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[STAGES-1];
        rise_d = sync_q[STAGES-1] & ~prev_q;
        fall_d = ~sync_q[STAGES-1] & prev_q;
    end

    // Reset to the bus idle level so reset release never fakes an edge.
    always_ff @(posedge clk12MHz) begin
        if (!rst) begin
            sync_q <= {STAGES{IDLE_LEVEL}};
            prev_q <= IDLE_LEVEL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level = prev_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/dac_spi_frame_rx.sv
// SPI slave receiver for 16-bit DAC frames (4-bit prefix + 12-bit data),
// oversampled by clk12MHz; accepted frames update rx_data/rx_prefix.
module dac_spi_frame_rx
    import dac_spi_pkg::*;
#(
    parameter logic [PREFIX_BITS-1:0] EXPECTED_PREFIX = DEFAULT_PREFIX,
    parameter int                     SYNC_STAGES     = 2
) (
    input  logic                   clk12MHz,
    input  logic                   rst,
    input  logic                   spi_cs_n,
    input  logic                   spi_sck,
    input  logic                   spi_sdi,
    output logic [DATA_BITS-1:0]   rx_data,
    output logic [PREFIX_BITS-1:0] rx_prefix,
    output logic                   rx_valid,
    output logic                   rx_err,
    output logic                   busy
);

    localparam int STAGES  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int FLUSH_W = STAGES + 2;

    logic cs_level, cs_rise, cs_fall;
    logic sck_level, sck_rise, sck_fall_unused;

    sync_edge_det #(.STAGES(STAGES), .IDLE_LEVEL(1'b1)) u_cs_sync (
        .clk12MHz (clk12MHz),
        .rst      (rst),
        .din      (spi_cs_n),
        .level    (cs_level),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    sync_edge_det #(.STAGES(STAGES), .IDLE_LEVEL(1'b1)) u_sck_sync (
        .clk12MHz (clk12MHz),
        .rst      (rst),
        .din      (spi_sck),
        .level    (sck_level),
        .rise     (sck_rise),
        .fall     (sck_fall_unused)
    );

    // One extra stage keeps sdi aligned with the registered sck edge pulse.
    logic [STAGES:0] sdi_sync_q, sdi_sync_d;
    logic            sdi_bit;

    rx_state_e                 state_q, state_d;
    logic [FRAME_BITS-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [DATA_BITS-1:0]      rx_data_q, rx_data_d;
    logic [PREFIX_BITS-1:0]    rx_prefix_q, rx_prefix_d;
    logic                      rx_valid_q, rx_valid_d;
    logic                      rx_err_q, rx_err_d;
    logic [FLUSH_W-1:0]        flush_q, flush_d;
    logic                      armed_q, armed_d;
    logic                      settled, accept, start;

    assign sdi_bit = sdi_sync_q[STAGES];
    assign settled = flush_q[FLUSH_W-1];
    assign start   = cs_fall & armed_q;
    assign accept  = (count_q == CNT_FULL) &&
                     (shift_q[FRAME_BITS-1 -: PREFIX_BITS] == EXPECTED_PREFIX);

    always_comb begin
        sdi_sync_d  = {sdi_sync_q[STAGES-1:0], spi_sdi};
        flush_d     = {flush_q[FLUSH_W-2:0], 1'b1};
        // A frame already under way at reset release is skipped until the bus idles.
        armed_d     = armed_q | (settled & cs_level & sck_level);
        state_d     = state_q;
        shift_d     = shift_q;
        count_d     = count_q;
        rx_data_d   = rx_data_q;
        rx_prefix_d = rx_prefix_q;
        rx_valid_d  = 1'b0;
        rx_err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    shift_d = '0;
                    count_d = '0;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    state_d = ST_CHECK;
                end else if (sck_rise) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], sdi_bit};
                    count_d = (count_q == CNT_SAT) ? CNT_SAT : count_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    rx_valid_d  = 1'b1;
                    rx_prefix_d = shift_q[FRAME_BITS-1 -: PREFIX_BITS];
                    rx_data_d   = shift_q[DATA_BITS-1:0];
                end else begin
                    rx_err_d = 1'b1;
                end
                if (start) begin
                    state_d = ST_SHIFT;
                    shift_d = '0;
                    count_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk12MHz) begin
        if (!rst) begin
            sdi_sync_q  <= '0;
            flush_q     <= '0;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            count_q     <= '0;
            rx_data_q   <= '0;
            rx_prefix_q <= '0;
            rx_valid_q  <= 1'b0;
            rx_err_q    <= 1'b0;
        end else begin
            sdi_sync_q  <= sdi_sync_d;
            flush_q     <= flush_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            rx_data_q   <= rx_data_d;
            rx_prefix_q <= rx_prefix_d;
            rx_valid_q  <= rx_valid_d;
            rx_err_q    <= rx_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_prefix = rx_prefix_q;
    assign rx_valid  = rx_valid_q;
    assign rx_err    = rx_err_q;
    assign busy      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_dac_spi_frame_rx.sv
// Directed bench for dac_spi_frame_rx: a vector table of whole frames plus
// hand-built sequences for latency, back-to-back, reset and idle-sck cases.
module tb_dac_spi_frame_rx;

    logic        clk12MHz = 1'b0;
    logic        rst      = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_sck  = 1'b1;
    logic        spi_sdi  = 1'b0;
    logic [11:0] rx_data;
    logic [3:0]  rx_prefix;
    logic        rx_valid;
    logic        rx_err;
    logic        busy;

    always #5 clk12MHz = ~clk12MHz;

    dac_spi_frame_rx dut (
        .clk12MHz  (clk12MHz),
        .rst       (rst),
        .spi_cs_n  (spi_cs_n),
        .spi_sck   (spi_sck),
        .spi_sdi   (spi_sdi),
        .rx_data   (rx_data),
        .rx_prefix (rx_prefix),
        .rx_valid  (rx_valid),
        .rx_err    (rx_err),
        .busy      (busy)
    );

    int errors = 0;
    int checks = 0;

    // Pulse monitor, sampled on the falling edge away from DUT updates.
    int          valid_cnt = 0;
    int          err_cnt   = 0;
    int          both_cnt  = 0;
    int          long_cnt  = 0;
    int          busy_hi   = 0;
    logic        prev_valid = 1'b0;
    logic        prev_err   = 1'b0;
    logic [11:0] cap_q[$];

    always @(negedge clk12MHz) begin
        if (rx_valid === 1'b1) begin
            valid_cnt++;
            cap_q.push_back(rx_data);
        end
        if (rx_err === 1'b1) err_cnt++;
        if (rx_valid === 1'b1 && rx_err === 1'b1) both_cnt++;
        if ((rx_valid === 1'b1 && prev_valid === 1'b1) ||
            (rx_err === 1'b1 && prev_err === 1'b1)) long_cnt++;
        if (busy === 1'b1) busy_hi++;
        prev_valid = rx_valid;
        prev_err   = rx_err;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk12MHz);
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        cyc(4);
    endtask

    task automatic send_bit(input logic b);
        spi_sck = 1'b0;
        spi_sdi = b;
        cyc(4);
        spi_sck = 1'b1;
        cyc(4);
    endtask

    task automatic send_open(input logic [31:0] bits, input int nbits);
        cs_low();
        for (int i = 0; i < nbits; i++) begin
            send_bit(bits[nbits-1-i]);
        end
    endtask

    task automatic send_frame(input logic [31:0] bits, input int nbits);
        send_open(bits, nbits);
        spi_cs_n = 1'b1;
    endtask

    typedef struct {
        string       name;
        logic [31:0] bits;
        int          nbits;
        int          exp_valid;
        int          exp_err;
        logic [11:0] exp_data;
        logic [3:0]  exp_prefix;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, e0, b0, lat;
        logic [31:0] part;

        vecs[0] = '{"good_3A5C",    32'h3A5C, 16, 1, 0, 12'hA5C, 4'h3};
        vecs[1] = '{"badpfx_9FFF",  32'h9FFF, 16, 0, 1, 12'hA5C, 4'h3};
        vecs[2] = '{"short_15",     32'h1D2E, 15, 0, 1, 12'hA5C, 4'h3};
        vecs[3] = '{"long_17",      32'h74B9, 17, 0, 1, 12'hA5C, 4'h3};
        vecs[4] = '{"good_3001",    32'h3001, 16, 1, 0, 12'h001, 4'h3};
        vecs[5] = '{"badpfx_2FFF",  32'h2FFF, 16, 0, 1, 12'h001, 4'h3};
        vecs[6] = '{"good_3FFF",    32'h3FFF, 16, 1, 0, 12'hFFF, 4'h3};

        // Reset state
        cyc(5);
        check("rst_rx_data",   32'(rx_data),   32'h0);
        check("rst_rx_prefix", 32'(rx_prefix), 32'h0);
        check("rst_rx_valid",  32'(rx_valid),  32'h0);
        check("rst_rx_err",    32'(rx_err),    32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        rst = 1'b1;
        cyc(10);

        // Table of whole frames
        for (int k = 0; k < 7; k++) begin
            v0 = valid_cnt;
            e0 = err_cnt;
            send_frame(vecs[k].bits, vecs[k].nbits);
            cyc(12);
            check({vecs[k].name, "_valid"},  32'(valid_cnt - v0), 32'(vecs[k].exp_valid));
            check({vecs[k].name, "_err"},    32'(err_cnt - e0),   32'(vecs[k].exp_err));
            check({vecs[k].name, "_data"},   32'(rx_data),        32'(vecs[k].exp_data));
            check({vecs[k].name, "_prefix"}, 32'(rx_prefix),      32'(vecs[k].exp_prefix));
        end

        // Latency from cs_n pin rise to rx_valid
        send_open(32'h35A5, 16);
        spi_cs_n = 1'b1;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk12MHz);
            #1;
            lat++;
            if (rx_valid === 1'b1) break;
        end
        check("latency_cycles", 32'(lat), 32'd5);
        check("latency_data",   32'(rx_data), 32'h5A5);
        cyc(10);

        // Back-to-back, cs_n high for 4 cycles
        cap_q.delete();
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(32'h3001, 16);
        cyc(4);
        send_frame(32'h3FFF, 16);
        cyc(12);
        check("b2b4_valid", 32'(valid_cnt - v0), 32'd2);
        check("b2b4_err",   32'(err_cnt - e0),   32'd0);
        check("b2b4_first",  (cap_q.size() > 0) ? 32'(cap_q[0]) : 32'hDEAD, 32'h001);
        check("b2b4_second", (cap_q.size() > 1) ? 32'(cap_q[1]) : 32'hDEAD, 32'hFFF);

        // cs_n high for one cycle: new frame starts while FSM is in CHECK
        cap_q.delete();
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(32'h3123, 16);
        cyc(1);
        send_frame(32'h3ABC, 16);
        cyc(12);
        check("b2b1_valid", 32'(valid_cnt - v0), 32'd2);
        check("b2b1_err",   32'(err_cnt - e0),   32'd0);
        check("b2b1_first",  (cap_q.size() > 0) ? 32'(cap_q[0]) : 32'hDEAD, 32'h123);
        check("b2b1_second", (cap_q.size() > 1) ? 32'(cap_q[1]) : 32'hDEAD, 32'hABC);

        // Reset mid-frame, released with cs_n still low
        v0 = valid_cnt;
        e0 = err_cnt;
        part = 32'h31;
        send_open(part, 8);
        check("midframe_busy", 32'(busy), 32'h1);
        rst = 1'b0;
        cyc(3);
        check("midrst_rx_data",   32'(rx_data),   32'h0);
        check("midrst_rx_prefix", 32'(rx_prefix), 32'h0);
        check("midrst_busy",      32'(busy),      32'h0);
        cyc(2);
        rst = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            part = 32'h23;
            send_bit(part[i]);
        end
        spi_cs_n = 1'b1;
        cyc(12);
        check("aborted_valid", 32'(valid_cnt - v0), 32'd0);
        check("aborted_err",   32'(err_cnt - e0),   32'd0);
        check("aborted_data",  32'(rx_data),        32'h0);
        v0 = valid_cnt;
        send_frame(32'h3000, 16);
        cyc(12);
        check("after_rst_valid",  32'(valid_cnt - v0), 32'd1);
        check("after_rst_data",   32'(rx_data),        32'h000);
        check("after_rst_prefix", 32'(rx_prefix),      32'h3);

        // sck toggling with cs_n high
        v0 = valid_cnt;
        e0 = err_cnt;
        b0 = busy_hi;
        for (int i = 0; i < 20; i++) begin
            spi_sck = ~spi_sck;
            spi_sdi = ~spi_sdi;
            cyc(4);
        end
        cyc(10);
        check("idle_sck_busy",   32'(busy_hi - b0),   32'd0);
        check("idle_sck_valid",  32'(valid_cnt - v0), 32'd0);
        check("idle_sck_err",    32'(err_cnt - e0),   32'd0);
        check("idle_sck_data",   32'(rx_data),        32'h000);
        check("idle_sck_prefix", 32'(rx_prefix),      32'h3);

        // Whole-run pulse properties
        check("valid_err_overlap", 32'(both_cnt), 32'd0);
        check("pulse_width",       32'(long_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dac_spi_frame_rx.md
DAC_SPI_FRAME_RX -- requirements
Module: dac_spi_frame_rx

Interface
REQ-001 Parameter: EXPECTED_PREFIX, default 4'b0011, prefix value that a frame must carry to be accepted.
REQ-002 Parameter: SYNC_STAGES, default 2, number of synchronizer flops per SPI input (minimum 2).
REQ-003 Port: clk12MHz  in  1  system clock; all logic on its rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-low.
REQ-005 Port: spi_cs_n  in  1  chip select, active-low, asynchronous to clk12MHz.
REQ-006 Port: spi_sck  in  1  SPI clock, idles high, asynchronous.
REQ-007 Port: spi_sdi  in  1  serial data, MSB first, asynchronous.
REQ-008 Port: rx_data  out  12  data field of last accepted frame.
REQ-009 Port: rx_prefix  out  4  prefix field of last accepted frame.
REQ-010 Port: rx_valid  out  1  one-cycle pulse, new rx_data/rx_prefix loaded.
REQ-011 Port: rx_err  out  1  one-cycle pulse, frame rejected.
REQ-012 Port: busy  out  1  high while a frame is in progress (state SHIFT).

Function
REQ-013 Frame SHALL be 16 bits: 4 prefix bits then 12 data bits, MSB first, enclosed by spi_cs_n low.
REQ-014 Each input SHALL pass through SYNC_STAGES flops; sck and sdi SHALL use equal depth so that they stay aligned.
REQ-015 Bits SHALL be sampled from synchronized sdi in the cycle when a synchronized sck rising edge is detected (data changes on falling sck).
REQ-016 Legal sck high and low phases SHALL each be >= 3 clk12MHz cycles; faster sck is out of spec.
REQ-017 States SHALL be IDLE, SHIFT, CHECK.
REQ-018 IDLE -> SHIFT on a synchronized cs_n falling edge; 16-bit shift register and 5-bit bit counter cleared.
REQ-019 In SHIFT, each sck rise SHALL shift in one bit and increment the counter, saturating at 17.
REQ-020 SHIFT -> CHECK on a synchronized cs_n rising edge; sck rise in that same cycle SHALL be ignored.
REQ-021 CHECK SHALL last one cycle, then IDLE; accept iff count == 16 and shift[15:12] == EXPECTED_PREFIX.
REQ-022 On accept: rx_prefix <= shift[15:12], rx_data <= shift[11:0], rx_valid = 1 for exactly the following cycle.
REQ-023 On reject: rx_err = 1 for exactly the following cycle; rx_data and rx_prefix SHALL hold their previous values.
REQ-024 Latency: rx_valid/rx_err SHALL assert SYNC_STAGES + 3 clk12MHz cycles after the cs_n pin rises.
REQ-025 sck edges while synchronized cs_n is high SHALL have no effect.
REQ-026 rx_valid and rx_err SHALL never be high in the same cycle.
REQ-027 A new cs_n falling edge during CHECK SHALL be honored: the FSM enters SHIFT straight after CHECK, losing no bits.

Reset
REQ-028 While rst == 0: state IDLE, counter 0, shift 0, rx_data 0, rx_prefix 0, rx_valid 0, rx_err 0, busy 0.
REQ-029 Synchronizer flops SHALL reset to idle levels (cs_n = 1, sck = 1, sdi = 0) so that reset release causes no false edge.
REQ-030 If cs_n is low at reset release, that frame SHALL be ignored; reception resumes at the next cs_n falling edge.
REQ-031 rst assertion mid-frame SHALL abort the frame with no rx_valid or rx_err pulse.

Structure
REQ-032 Package dac_spi_pkg SHALL hold FRAME_BITS = 16, PREFIX_BITS = 4, DATA_BITS = 12, DEFAULT_PREFIX = 4'b0011, and the state encoding.
REQ-033 Sub-module sync_edge_det (synchronizer plus rise/fall pulse outputs) SHALL be instantiated for cs_n and sck; sdi uses the synchronizer only.

Verification
REQ-034 Frame 16'h3A5C -> one rx_valid pulse, rx_prefix = 4'h3, rx_data = 12'hA5C, no rx_err.
REQ-035 Frame 16'h9FFF -> one rx_err pulse, rx_data/rx_prefix unchanged from the prior value.
REQ-036 15-bit frame, then a 17-bit frame -> an rx_err pulse for each, no rx_valid.
REQ-037 rst low after 8 bits of 16'h3123 -> all outputs 0, no pulses; next frame 16'h3000 -> rx_valid, rx_data = 12'h000.
REQ-038 Back-to-back frames 16'h3001 and 16'h3FFF with cs_n high for 4 cycles -> two rx_valid pulses carrying 12'h001 then 12'hFFF.
REQ-039 sck toggling 20 times with cs_n high -> busy stays 0, no pulses, outputs unchanged.
